crc_frame_engine: RTL and testbench
===================================

Name: crc_frame_engine

Overview:
- Parametrised successor to the fixed CRC-8 frame block. Sits in the same line datapath, between the framer and the line output on map, and between the line input and the deframer on demap.
- Computes a CRC of configurable width and polynomial over frame payload columns, with configurable frame geometry.
- Map mode: inserts the CRC as a multi-byte field. Demap mode: checks the field, counts errored frames and runs a consecutive-error alarm state machine.

Parameters:
MAP_MODE, 1, 1 = insert CRC, 0 = check CRC; any other value is an elaboration error
CRC_W, 8, CRC width; must be 8, 16 or 32; CRC_BYTES = CRC_W/8
POLY, 8'h07, polynomial without the x^CRC_W term, CRC_W bits wide
INIT, 0, CRC register value at start of frame
ROWS, 4, rows per frame
OH_COLS, 16, overhead columns per row, numbered 0..OH_COLS-1
PL_COLS, 1024, payload columns per row, numbered OH_COLS..OH_COLS+PL_COLS-1
ERR_THRESH, 3, consecutive errored frames needed to raise the alarm
CLR_THRESH, 2, consecutive good frames needed to clear the alarm

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous, active-low reset
i_row_cnt  in  $clog2(ROWS)  row of the current beat
i_col_cnt  in  11  column of the current beat
i_frame_data  in  8  line data
i_frame_data_valid  in  1  beat valid
i_frame_data_fas  in  1  frame alignment marker, passed through
i_err_cnt_clr  in  1  synchronous clear of o_err_cnt
o_frame_data  out  8  line data out
o_frame_data_valid  out  1  valid out
o_frame_data_fas  out  1  FAS out
o_crc_val  out  CRC_W  computed CRC of the last completed frame
o_crc_err  out  1  demap only: verdict of the last checked frame
o_crc_err_valid  out  1  demap only: one-cycle verdict strobe
o_err_cnt  out  16  demap only: saturating count of errored frames
o_crc_alarm  out  1  demap only: alarm state

Behaviour:
- Reset: all outputs and internal state are 0; the FSM goes to WAIT_SOF. Reset acts asynchronously in any state, including mid-frame.
- Datapath: registered with 1-cycle latency. Valid and FAS are always forwarded.
- Data forwarding: data passes through unchanged, except in map mode on CRC-field beats.
- Valid-low beats: forwarded; the FSM and CRC register hold.
- CRC update, per payload byte: for b = 7 down to 0, fb = crc[CRC_W-1] ^ d[b]; crc = (crc << 1) ^ (fb ? POLY : 0). Bits are MSB-first, with no reflection and no final XOR.
- The CRC register updates on valid beats in ACCUM only, with column in the payload range on any row.
- CRC field: row ROWS-1, columns C0 = OH_COLS+PL_COLS .. C0+CRC_BYTES-1. Byte k carries crc[CRC_W-1-8k -: 8], MSB byte first.
- FSM states and transitions:
  - WAIT_SOF -> ACCUM on a valid beat at row 0, col 0; the CRC register loads INIT. Beats before this are forwarded with no verdict.
  - In ACCUM, a valid row-0/col-0 beat reloads INIT; the previous frame is abandoned with no verdict.
  - ACCUM -> CRC_FIELD on a valid beat at (ROWS-1, C0). The final CRC is latched into o_crc_val; byte index k = 0.
  - CRC_FIELD: k increments per valid beat. Map mode: o_frame_data = latched byte k. Demap mode: the received byte is compared with latched byte k, and any mismatch sets a sticky mismatch flag.
  - After byte CRC_BYTES-1 -> ACCUM.
  - A valid row-0/col-0 beat arriving in CRC_FIELD means a truncated field: no verdict, reload INIT, go to ACCUM.
- Verdict (demap): o_crc_err_valid pulses for 1 cycle, coincident with the last CRC byte on o_frame_data. o_crc_err equals the mismatch flag and holds until the next verdict.
- Error counter: increments on each errored verdict and saturates at 16'hFFFF. i_err_cnt_clr clears it. A clear coincident with an errored verdict gives 1.
- Alarm FSM:
  - OK -> ALARM after ERR_THRESH consecutive errored verdicts.
  - ALARM -> OK after CLR_THRESH consecutive good verdicts.
  - An opposite verdict resets the run counter.
  - o_crc_alarm = (state == ALARM), updated in the verdict cycle.
- Map mode: o_crc_err, o_crc_err_valid, o_err_cnt and o_crc_alarm are held at 0.

Test Plan:
- Map, CRC_W=8, POLY=07, INIT=0, ROWS=1, OH_COLS=1, PL_COLS=9, payload "123456789" -> o_frame_data = 8'hF4 at col 10; o_crc_val = F4.
- Map, CRC_W=16, POLY=1021, INIT=FFFF, same geometry, with the 2-byte field at cols 10..11 -> bytes 29, B1; o_crc_val = 16'h29B1.
- Demap, defaults, all-zero payload, INIT=0, received CRC 00 -> o_crc_err_valid pulse with err=0, o_err_cnt=0. Same frame with CRC 01 -> err=1, count=1.
- Demap, ERR_THRESH=3, CLR_THRESH=2, verdict sequence bad ×3, good, good -> alarm rises on the 3rd verdict and falls on the 5th; o_err_cnt=3. Assert i_err_cnt_clr in the same cycle as the 3rd bad verdict -> count=1.
- Valid low for 5 cycles mid-payload -> CRC result identical to a gapless frame.
- i_rst_n low mid-frame -> all outputs 0 immediately. After release, the partial frame gives no verdict; the next full frame is checked correctly.

Source files
------------

// File: rtl/crc_frame_engine.sv
// crc_frame_engine: CRC insert (map) or check (demap) on a framed byte
// stream, with errored-frame counter and consecutive-error alarm.
module crc_frame_engine #(
  parameter int               MAP_MODE   = 1,
  parameter int               CRC_W      = 8,
  parameter logic [CRC_W-1:0] POLY       = 8'h07,
  parameter logic [CRC_W-1:0] INIT       = '0,
  parameter int               ROWS       = 4,
  parameter int               OH_COLS    = 16,
  parameter int               PL_COLS    = 1024,
  parameter int               ERR_THRESH = 3,
  parameter int               CLR_THRESH = 2
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic [(ROWS>1 ? $clog2(ROWS) : 1)-1:0] i_row_cnt,
  input  logic [10:0]                            i_col_cnt,
  input  logic [7:0]                             i_frame_data,
  input  logic                                   i_frame_data_valid,
  input  logic                                   i_frame_data_fas,
  input  logic                                   i_err_cnt_clr,
  output logic [7:0]                             o_frame_data,
  output logic                                   o_frame_data_valid,
  output logic                                   o_frame_data_fas,
  output logic [CRC_W-1:0]                       o_crc_val,
  output logic                                   o_crc_err,
  output logic                                   o_crc_err_valid,
  output logic [15:0]                            o_err_cnt,
  output logic                                   o_crc_alarm
);

  localparam int CRC_BYTES = CRC_W / 8;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int KW = (CRC_BYTES > 1) ? $clog2(CRC_BYTES) : 1;
  localparam int RUN_MAX = (ERR_THRESH > CLR_THRESH) ? ERR_THRESH : CLR_THRESH;
  localparam int NW = $clog2(RUN_MAX + 1);

  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [10:0]   PL_LO    = 11'(OH_COLS);
  localparam logic [10:0]   PL_HI    = 11'(OH_COLS + PL_COLS - 1);
  localparam logic [10:0]   C0       = 11'(OH_COLS + PL_COLS);
  localparam logic [KW-1:0] K_LAST   = KW'(CRC_BYTES - 1);
  localparam logic [KW-1:0] K_ONE    = KW'(1);
  localparam logic [NW-1:0] ERR_LAST = NW'(ERR_THRESH - 1);
  localparam logic [NW-1:0] CLR_LAST = NW'(CLR_THRESH - 1);
  localparam logic [NW-1:0] RUN_ONE  = NW'(1);

  generate
    if (MAP_MODE != 0 && MAP_MODE != 1) begin : g_chk_mode
      $error("crc_frame_engine: MAP_MODE must be 0 or 1");
    end
    if (CRC_W != 8 && CRC_W != 16 && CRC_W != 32) begin : g_chk_w
      $error("crc_frame_engine: CRC_W must be 8, 16 or 32");
    end
    if (ERR_THRESH < 1 || CLR_THRESH < 1) begin : g_chk_thr
      $error("crc_frame_engine: thresholds must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_WAIT_SOF,
    S_ACCUM,
    S_CRC_FIELD
  } st_t;

  typedef enum logic {
    A_OK,
    A_ALARM
  } al_t;

  function automatic logic [CRC_W-1:0] f_step(
    input logic [CRC_W-1:0] c,
    input logic [7:0]       d
  );
    logic [CRC_W-1:0] r;
    r = c;
    for (int b = 7; b >= 0; b--) begin
      r = {r[CRC_W-2:0], 1'b0} ^ ((r[CRC_W-1] ^ d[b]) ? POLY : '0);
    end
    return r;
  endfunction

  function automatic logic [7:0] f_byte(
    input logic [CRC_W-1:0] c,
    input logic [KW-1:0]    k
  );
    logic [CRC_W-1:0] s;
    s = c << {k, 3'b000};
    return s[CRC_W-1 -: 8];
  endfunction

  st_t              r_st, w_st_n;
  al_t              r_al, w_al_n;
  logic [CRC_W-1:0] r_crc, w_crc_n;
  logic [CRC_W-1:0] r_crc_val, w_crc_val_n;
  logic [KW-1:0]    r_k, w_k_n;
  logic             r_mis, w_mis_n;
  logic [7:0]       r_data, w_data_n;
  logic             r_valid, r_fas;
  logic             r_err, r_err_v;
  logic [15:0]      r_cnt, w_cnt_n;
  logic [NW-1:0]    r_run, w_run_n;

  logic             w_sof, w_c0, w_pl, w_in_field;
  logic [7:0]       w_byte;
  logic             w_mis_now;
  logic             w_vdt, w_vdt_err, w_vdt_en;

  assign w_sof = (i_row_cnt == '0) && (i_col_cnt == '0);
  assign w_c0  = (i_row_cnt == ROW_LAST) && (i_col_cnt == C0);
  assign w_pl  = (i_col_cnt >= PL_LO) && (i_col_cnt <= PL_HI);

  // Byte 0 comes straight from the running CRC on the C0 beat itself.
  assign w_in_field = (r_st == S_CRC_FIELD);
  assign w_byte = f_byte(w_in_field ? r_crc_val : r_crc,
                         w_in_field ? r_k : '0);
  assign w_mis_now = (i_frame_data != w_byte);

  always_comb begin
    w_st_n      = r_st;
    w_crc_n     = r_crc;
    w_crc_val_n = r_crc_val;
    w_k_n       = r_k;
    w_mis_n     = r_mis;
    w_data_n    = i_frame_data;
    w_vdt       = 1'b0;
    w_vdt_err   = 1'b0;
    if (i_frame_data_valid) begin
      unique case (r_st)
        S_WAIT_SOF: begin
          if (w_sof) begin
            w_st_n  = S_ACCUM;
            w_crc_n = INIT;
          end
        end
        S_ACCUM: begin
          if (w_sof) begin
            w_crc_n = INIT;
          end else if (w_c0) begin
            w_crc_val_n = r_crc;
            if (MAP_MODE == 1) w_data_n = w_byte;
            if (CRC_BYTES == 1) begin
              w_vdt     = 1'b1;
              w_vdt_err = w_mis_now;
            end else begin
              w_st_n  = S_CRC_FIELD;
              w_k_n   = K_ONE;
              w_mis_n = w_mis_now;
            end
          end else if (w_pl) begin
            w_crc_n = f_step(r_crc, i_frame_data);
          end
        end
        S_CRC_FIELD: begin
          if (w_sof) begin
            w_st_n  = S_ACCUM;
            w_crc_n = INIT;
          end else begin
            if (MAP_MODE == 1) w_data_n = w_byte;
            w_mis_n = r_mis | w_mis_now;
            if (r_k == K_LAST) begin
              w_st_n    = S_ACCUM;
              w_vdt     = 1'b1;
              w_vdt_err = r_mis | w_mis_now;
            end else begin
              w_k_n = r_k + K_ONE;
            end
          end
        end
        default: w_st_n = S_WAIT_SOF;
      endcase
    end
  end

  assign w_vdt_en = (MAP_MODE == 0) && w_vdt;

  always_comb begin
    w_al_n  = r_al;
    w_run_n = r_run;
    w_cnt_n = r_cnt;
    if (w_vdt_en) begin
      unique case (r_al)
        A_OK: begin
          if (!w_vdt_err) begin
            w_run_n = '0;
          end else if (r_run == ERR_LAST) begin
            w_al_n  = A_ALARM;
            w_run_n = '0;
          end else begin
            w_run_n = r_run + RUN_ONE;
          end
        end
        A_ALARM: begin
          if (w_vdt_err) begin
            w_run_n = '0;
          end else if (r_run == CLR_LAST) begin
            w_al_n  = A_OK;
            w_run_n = '0;
          end else begin
            w_run_n = r_run + RUN_ONE;
          end
        end
      endcase
    end
    // A clear that meets an errored verdict still counts that verdict.
    if (w_vdt_en && w_vdt_err) begin
      if (i_err_cnt_clr)  w_cnt_n = 16'd1;
      else if (~&r_cnt)   w_cnt_n = r_cnt + 16'd1;
    end else if (i_err_cnt_clr) begin
      w_cnt_n = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_st      <= S_WAIT_SOF;
      r_al      <= A_OK;
      r_crc     <= '0;
      r_crc_val <= '0;
      r_k       <= '0;
      r_mis     <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_fas     <= 1'b0;
      r_err     <= 1'b0;
      r_err_v   <= 1'b0;
      r_cnt     <= '0;
      r_run     <= '0;
    end else begin
      r_st      <= w_st_n;
      r_al      <= w_al_n;
      r_crc     <= w_crc_n;
      r_crc_val <= w_crc_val_n;
      r_k       <= w_k_n;
      r_mis     <= w_mis_n;
      r_data    <= w_data_n;
      r_valid   <= i_frame_data_valid;
      r_fas     <= i_frame_data_fas;
      r_err_v   <= w_vdt_en;
      if (w_vdt_en) r_err <= w_vdt_err;
      r_cnt     <= w_cnt_n;
      r_run     <= w_run_n;
    end
  end

  assign o_frame_data       = r_data;
  assign o_frame_data_valid = r_valid;
  assign o_frame_data_fas   = r_fas;
  assign o_crc_val          = r_crc_val;
  assign o_crc_err          = r_err;
  assign o_crc_err_valid    = r_err_v;
  assign o_err_cnt          = r_cnt;
  assign o_crc_alarm        = (r_al == A_ALARM);

endmodule

// File: tb/tb_crc_frame_engine.sv
// tb_crc_frame_engine: four engines (map/demap x CRC-8/CRC-16) on one
// 12-column single-row line: overhead col 0, payload 1..9, field 10..11.
`timescale 1ns/1ps
module tb_crc_frame_engine;

  localparam logic [71:0] KAT = 72'h313233343536373839;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [0:0]  row = '0;
  logic [10:0] col = '0;
  logic [7:0]  din = '0;
  logic        vin = 1'b0;
  logic        fin = 1'b0;
  logic        clr = 1'b0;

  logic [7:0]  od  [4];
  logic        ov  [4];
  logic        ofs [4];
  logic        oe  [4];
  logic        oev [4];
  logic        oal [4];
  logic [15:0] oc  [4];
  logic [7:0]  cv_m8, cv_d8;
  logic [15:0] cv_m16, cv_d16;

  int total = 0;
  int bad = 0;

  logic [7:0]  g_c8;
  logic [15:0] g_c16;

  always #5 clk = ~clk;

  crc_frame_engine #(
    .MAP_MODE(1), .CRC_W(8), .POLY(8'h07), .INIT(8'h00),
    .ROWS(1), .OH_COLS(1), .PL_COLS(9)
  ) u_m8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_row_cnt(row), .i_col_cnt(col),
    .i_frame_data(din), .i_frame_data_valid(vin),
    .i_frame_data_fas(fin), .i_err_cnt_clr(clr),
    .o_frame_data(od[0]), .o_frame_data_valid(ov[0]),
    .o_frame_data_fas(ofs[0]), .o_crc_val(cv_m8), .o_crc_err(oe[0]),
    .o_crc_err_valid(oev[0]), .o_err_cnt(oc[0]), .o_crc_alarm(oal[0])
  );

  crc_frame_engine #(
    .MAP_MODE(1), .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF),
    .ROWS(1), .OH_COLS(1), .PL_COLS(9)
  ) u_m16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_row_cnt(row), .i_col_cnt(col),
    .i_frame_data(din), .i_frame_data_valid(vin),
    .i_frame_data_fas(fin), .i_err_cnt_clr(clr),
    .o_frame_data(od[1]), .o_frame_data_valid(ov[1]),
    .o_frame_data_fas(ofs[1]), .o_crc_val(cv_m16), .o_crc_err(oe[1]),
    .o_crc_err_valid(oev[1]), .o_err_cnt(oc[1]), .o_crc_alarm(oal[1])
  );

  crc_frame_engine #(
    .MAP_MODE(0), .CRC_W(8), .POLY(8'h07), .INIT(8'h00),
    .ROWS(1), .OH_COLS(1), .PL_COLS(9),
    .ERR_THRESH(3), .CLR_THRESH(2)
  ) u_d8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_row_cnt(row), .i_col_cnt(col),
    .i_frame_data(din), .i_frame_data_valid(vin),
    .i_frame_data_fas(fin), .i_err_cnt_clr(clr),
    .o_frame_data(od[2]), .o_frame_data_valid(ov[2]),
    .o_frame_data_fas(ofs[2]), .o_crc_val(cv_d8), .o_crc_err(oe[2]),
    .o_crc_err_valid(oev[2]), .o_err_cnt(oc[2]), .o_crc_alarm(oal[2])
  );

  crc_frame_engine #(
    .MAP_MODE(0), .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF),
    .ROWS(1), .OH_COLS(1), .PL_COLS(9)
  ) u_d16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_row_cnt(row), .i_col_cnt(col),
    .i_frame_data(din), .i_frame_data_valid(vin),
    .i_frame_data_fas(fin), .i_err_cnt_clr(clr),
    .o_frame_data(od[3]), .o_frame_data_valid(ov[3]),
    .o_frame_data_fas(ofs[3]), .o_crc_val(cv_d16), .o_crc_err(oe[3]),
    .o_crc_err_valid(oev[3]), .o_err_cnt(oc[3]), .o_crc_alarm(oal[3])
  );

  typedef struct packed {
    logic       v;
    logic       fas;
    logic [7:0] din;
    logic [7:0] m8;
    logic [7:0] m16;
    logic       ev8;
    logic       ee8;
    logic       ev16;
    logic       ee16;
  } exp_t;

  typedef struct packed {
    logic [71:0] pl;
    logic [7:0]  f0;
    logic [7:0]  f1;
    logic [7:0]  gap;
    logic        kat;
    logic [7:0]  c8;
    logic [15:0] c16;
    logic [15:0] cnt;
    logic        alarm;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[6];

  function automatic logic [31:0] m_crc(
    input int          w,
    input logic [31:0] poly,
    input logic [31:0] init,
    input logic [71:0] pl
  );
    logic [31:0] c, msk;
    logic [7:0]  d;
    logic        fb;
    msk = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    c = init;
    for (int i = 0; i < 9; i++) begin
      d = pl[71-8*i -: 8];
      for (int b = 7; b >= 0; b--) begin
        fb = c[w-1] ^ d[b];
        c = ((c << 1) ^ (fb ? poly : 32'h0)) & msk;
      end
    end
    return c;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_bits"},
        64'({od[0], od[1], od[2], od[3],
             ov[0], ov[1], ov[2], ov[3], ofs[0], ofs[1], ofs[2], ofs[3],
             oe[0], oe[1], oe[2], oe[3], oev[0], oev[1], oev[2], oev[3],
             oal[0], oal[1], oal[2], oal[3]}), 64'h0);
    chk({nm, "_cnt"}, {oc[0], oc[1], oc[2], oc[3]}, 64'h0);
    chk({nm, "_crc"}, 64'({cv_m8, cv_m16, cv_d8, cv_d16}), 64'h0);
  endtask

  task automatic beat(input int c, input logic [7:0] d, input logic v,
                      input logic fas, input logic cl, input logic framed,
                      input logic [7:0] f0, input logic [7:0] f1);
    exp_t e, g;
    col = 11'(c);
    din = d;
    vin = v;
    fin = fas;
    clr = cl;
    e = '{v: v, fas: fas, din: d, m8: d, m16: d, default: 1'b0};
    if (framed && v && c == 10) begin
      e.m8  = g_c8;
      e.m16 = g_c16[15:8];
      e.ev8 = 1'b1;
      e.ee8 = (f0 != g_c8);
    end
    if (framed && v && c == 11) begin
      e.m16  = g_c16[7:0];
      e.ev16 = 1'b1;
      e.ee16 = ({f0, f1} != g_c16);
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    clr = 1'b0;
    g = sbq.pop_front();
    chk("data", 64'({od[0], od[1], od[2], od[3]}),
        64'({g.m8, g.m16, g.din, g.din}));
    chk("vld_fas",
        64'({ov[0], ov[1], ov[2], ov[3], ofs[0], ofs[1], ofs[2], ofs[3]}),
        64'({{4{g.v}}, {4{g.fas}}}));
    chk("strobe", 64'({oev[0], oev[1], oev[2], oev[3]}),
        64'({2'b00, g.ev8, g.ev16}));
    if (g.ev8)  chk("err8", 64'(oe[2]), 64'(g.ee8));
    if (g.ev16) chk("err16", 64'(oe[3]), 64'(g.ee16));
  endtask

  task automatic frame(input logic [71:0] pl, input logic [7:0] f0,
                       input logic [7:0] f1, input int gap_at,
                       input int c_lo, input int c_hi, input logic clr_f);
    logic [7:0] d;
    logic       framed;
    g_c8   = 8'(m_crc(8, 32'h07, 32'h0, pl));
    g_c16  = 16'(m_crc(16, 32'h1021, 32'hFFFF, pl));
    framed = (c_lo == 0);
    for (int c = c_lo; c <= c_hi; c++) begin
      if (c == gap_at) begin
        for (int j = 0; j < 5; j++) begin
          beat(c, 8'($urandom), 1'b0, 1'b0, 1'b0, framed, f0, f1);
        end
      end
      if (c == 0)       d = 8'hA5;
      else if (c <= 9)  d = pl[71-8*(c-1) -: 8];
      else if (c == 10) d = f0;
      else              d = f1;
      beat(c, d, 1'b1, (c == 0), (clr_f && c == 10), framed, f0, f1);
    end
  endtask

  task automatic af(input logic is_bad, input logic cl,
                    input logic exp_al, input logic [15:0] exp_cnt);
    frame(72'h0, is_bad ? 8'h01 : 8'h00, 8'h00, -1, 0, 11, cl);
    chk("alarm_seq", 64'({oal[2], oc[2]}), 64'({exp_al, exp_cnt}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [95:0] rnd;
    vt[0] = '{KAT,   8'hF4, 8'h00, 8'd0, 1'b1, 8'hF4, 16'h29B1, 16'd0, 1'b0};
    vt[1] = '{KAT,   8'h29, 8'hB1, 8'd0, 1'b1, 8'hF4, 16'h29B1, 16'd1, 1'b0};
    vt[2] = '{72'h0, 8'h00, 8'h00, 8'd0, 1'b0, 8'h00, 16'h0000, 16'd1, 1'b0};
    vt[3] = '{72'h0, 8'h01, 8'h00, 8'd0, 1'b0, 8'h00, 16'h0000, 16'd2, 1'b0};
    vt[4] = '{KAT,   8'hF4, 8'h00, 8'd5, 1'b1, 8'hF4, 16'h29B1, 16'd2, 1'b0};
    rnd = {$urandom, $urandom, $urandom};
    vt[5] = '{rnd[71:0], 8'h00, 8'h00, 8'd0, 1'b0, 8'h00, 16'h0, 16'd2, 1'b0};
    vt[5].f0 = 8'(m_crc(8, 32'h07, 32'h0, vt[5].pl));

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_state");
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      frame(vt[i].pl, vt[i].f0, vt[i].f1,
            (vt[i].gap == 8'd0) ? -1 : int'(vt[i].gap), 0, 11, 1'b0);
      chk("crc_val", 64'({cv_m8, cv_m16, cv_d8, cv_d16}),
          64'({g_c8, g_c16, g_c8, g_c16}));
      if (vt[i].kat) begin
        chk("kat", 64'({cv_m8, cv_m16}), 64'({vt[i].c8, vt[i].c16}));
      end
      chk("cnt_alarm", 64'({oc[2], oal[2]}), 64'({vt[i].cnt, vt[i].alarm}));
      chk("map_quiet", 64'({oc[0], oc[1], oal[0], oal[1], oe[0], oe[1]}),
          64'h0);
    end

    beat(0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    chk("cnt_clear", 64'(oc[2]), 64'h0);

    af(1'b1, 1'b0, 1'b0, 16'd1);
    af(1'b1, 1'b0, 1'b0, 16'd2);
    af(1'b1, 1'b0, 1'b1, 16'd3);
    af(1'b0, 1'b0, 1'b1, 16'd3);
    af(1'b0, 1'b0, 1'b0, 16'd3);
    af(1'b1, 1'b0, 1'b0, 16'd4);
    af(1'b1, 1'b0, 1'b0, 16'd5);
    af(1'b1, 1'b1, 1'b1, 16'd1);
    af(1'b0, 1'b0, 1'b1, 16'd1);
    af(1'b1, 1'b0, 1'b1, 16'd2);
    af(1'b0, 1'b0, 1'b1, 16'd2);

    frame(KAT, 8'hF4, 8'h00, -1, 0, 5, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    frame(KAT, 8'h5A, 8'h00, -1, 6, 11, 1'b0);
    chk("partial_cnt", 64'({oc[2], oal[2], oe[2]}), 64'h0);
    frame(KAT, 8'hF4, 8'h00, -1, 0, 11, 1'b0);
    chk("post_reset", 64'({cv_d8, cv_m16, oc[2]}),
        64'({8'hF4, 16'h29B1, 16'd0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
